// File: rtl/score_cal_sad.sv
// score_cal_sad: two-stage SAD scorer for 5-element window pairs.
// Tracks the minimum score and its window index per frame, and reports the
// frame's best match with a one-cycle done pulse.
module score_cal_sad #(
    parameter int unsigned NUM_WIN = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             win_valid,
    input  logic [39:0]      data_out_a_all,
    input  logic [39:0]      data_out_b_all,
    input  logic             frame_clr,
    output logic [10:0]      score_out,
    output logic             score_valid,
    output logic [10:0]      best_score,
    output logic [IDX_W-1:0] best_idx,
    output logic             score_done,
    output logic             busy
);

    localparam int unsigned ELEM_N  = 5;
    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned SCORE_W = 11;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WIN - 1);
    localparam logic [SCORE_W-1:0] MIN_INIT = '1;

    // Stage-1 state
    logic [ELEM_W-1:0]  s1_diff [ELEM_N];
    logic [IDX_W-1:0]   s1_tag;
    logic               s1_valid;
    logic [IDX_W-1:0]   cnt;

    // Running frame minimum
    logic [SCORE_W-1:0] run_min;
    logic [IDX_W-1:0]   run_idx;

    // Combinational helpers
    logic [ELEM_W-1:0]  diff_c [ELEM_N];
    logic [SCORE_W-1:0] sum_c;
    logic               better_c;
    logic [SCORE_W-1:0] min_c;
    logic [IDX_W-1:0]   idx_c;
    logic               last_c;

    // Next-state values
    logic [IDX_W-1:0]   cnt_nxt;
    logic               s1_valid_nxt;
    logic               score_valid_nxt;
    logic               score_done_nxt;
    logic [SCORE_W-1:0] score_out_nxt;
    logic [SCORE_W-1:0] run_min_nxt;
    logic [IDX_W-1:0]   run_idx_nxt;
    logic [SCORE_W-1:0] best_score_nxt;
    logic [IDX_W-1:0]   best_idx_nxt;
    logic               busy_nxt;

    // Per-element absolute differences of the incoming window pair
    always_comb begin
        for (int k = 0; k < ELEM_N; k++) begin
            diff_c[k] = '0;
            if (data_out_a_all[ELEM_W*k +: ELEM_W] >= data_out_b_all[ELEM_W*k +: ELEM_W])
                diff_c[k] = data_out_a_all[ELEM_W*k +: ELEM_W] - data_out_b_all[ELEM_W*k +: ELEM_W];
            else
                diff_c[k] = data_out_b_all[ELEM_W*k +: ELEM_W] - data_out_a_all[ELEM_W*k +: ELEM_W];
        end
    end

    // Stage-2 sum and min-compare against the running frame minimum
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < ELEM_N; k++)
            sum_c = sum_c + SCORE_W'(s1_diff[k]);
        better_c = (sum_c < run_min);
        min_c    = better_c ? sum_c  : run_min;
        idx_c    = better_c ? s1_tag : run_idx;
        last_c   = (s1_tag == LAST_IDX);
    end

    // Next-state logic; frame_clr drops everything in flight but keeps the last best
    always_comb begin
        cnt_nxt         = cnt;
        s1_valid_nxt    = 1'b0;
        score_valid_nxt = 1'b0;
        score_done_nxt  = 1'b0;
        score_out_nxt   = score_out;
        run_min_nxt     = run_min;
        run_idx_nxt     = run_idx;
        best_score_nxt  = best_score;
        best_idx_nxt    = best_idx;

        if (frame_clr) begin
            cnt_nxt     = '0;
            run_min_nxt = MIN_INIT;
            run_idx_nxt = '0;
        end else begin
            if (win_valid) begin
                s1_valid_nxt = 1'b1;
                cnt_nxt      = (cnt == LAST_IDX) ? '0 : cnt + IDX_W'(1);
            end
            if (s1_valid) begin
                score_valid_nxt = 1'b1;
                score_out_nxt   = sum_c;
                if (last_c) begin
                    best_score_nxt = min_c;
                    best_idx_nxt   = idx_c;
                    score_done_nxt = 1'b1;
                    run_min_nxt    = MIN_INIT;
                    run_idx_nxt    = '0;
                end else begin
                    run_min_nxt = min_c;
                    run_idx_nxt = idx_c;
                end
            end
        end

        busy_nxt = (cnt_nxt != '0) || s1_valid_nxt || score_valid_nxt;
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            s1_valid    <= 1'b0;
            score_valid <= 1'b0;
            score_done  <= 1'b0;
            score_out   <= '0;
            run_min     <= MIN_INIT;
            run_idx     <= '0;
            best_score  <= '0;
            best_idx    <= '0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            s1_valid    <= s1_valid_nxt;
            score_valid <= score_valid_nxt;
            score_done  <= score_done_nxt;
            score_out   <= score_out_nxt;
            run_min     <= run_min_nxt;
            run_idx     <= run_idx_nxt;
            best_score  <= best_score_nxt;
            best_idx    <= best_idx_nxt;
            busy        <= busy_nxt;
        end
    end

    // Stage-1 payload: differences and window tag, loaded with each accepted window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ELEM_N; k++)
                s1_diff[k] <= '0;
            s1_tag <= '0;
        end else if (win_valid) begin
            for (int k = 0; k < ELEM_N; k++)
                s1_diff[k] <= diff_c[k];
            s1_tag <= cnt;
        end
    end

endmodule

// File: doc/score_cal_sad.md
Name: score_cal_sad

Overview:
Downstream consumer of the 5-point window buffer. Takes each pair of 5-element windows (sequence A and sequence B) and computes a sum of absolute differences (SAD) score through a 2-stage pipeline. Over a frame of NUM_WIN windows it tracks the minimum score and its window index, then reports the frame's best match and a one-cycle done pulse to the match controller.

Parameters:
NUM_WIN, 16, number of windows per frame (range 2..2^IDX_W)
IDX_W, 4, width of the window index / counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
win_valid  input  1  one window pair present on data inputs this cycle
data_out_a_all  input  40  sequence-A window; element k in bits [8k+7:8k], element 0 in LSBs
data_out_b_all  input  40  sequence-B window, same packing
frame_clr  input  1  synchronous frame abort/restart
score_out  output  11  SAD of the most recent window
score_valid  output  1  score_out valid this cycle (1-cycle pulse per window)
best_score  output  11  minimum SAD of the last completed frame
best_idx  output  IDX_W  window index (0-based) of best_score
score_done  output  1  1-cycle pulse: best_score/best_idx updated
busy  output  1  high while a frame is partially accumulated or in flight

Behaviour:
- Reset (rst=0, async): all outputs 0; window counter 0; running minimum = 11'h7FF; running index 0; pipeline valid bits 0.
- Stage 1 (edge after win_valid=1): register 5 unsigned 8-bit |a_k - b_k| values, tag with current window index, then increment counter.
- Stage 2 (next edge): register score_out = zero-extended sum of the 5 differences (max 1275, no saturation), assert score_valid for 1 cycle.
- Latency: score_valid is high exactly 2 cycles after the win_valid cycle. Full throughput, one window per cycle, no back-pressure.
- Running-min update on the same edge that sets score_valid: if score < running_min (strict), running_min <= score and running_idx <= tag. On ties the earlier index is kept.
- Frame end: when the tag of the stage-2 window equals NUM_WIN-1:
  - best_score/best_idx are loaded with the final min/index, including this window.
  - score_done pulses on that edge (coincident with the last score_valid).
  - running_min is reloaded to 7FF and running_idx to 0 for the next frame.
- Window counter wraps to 0 after NUM_WIN-1. A window arriving in the cycle after the last one belongs to the next frame, with no bubble required.
- best_score/best_idx hold between done pulses.
- busy = counter != 0 OR either pipeline valid bit set.
- frame_clr=1 (synchronous, priority over everything except rst):
  - Clears the counter, both pipeline valid bits, running_min (7FF) and running_idx.
  - A win_valid in the same cycle is discarded.
  - No score_valid or score_done is produced for in-flight windows.
  - best_score/best_idx keep the previous frame's result.
- Reset asserted mid-frame: immediate clear per the reset list. No done pulse for the partial frame.
- win_valid=0 cycles are ignored; the frame can be spread over any number of cycles.

Test Plan:
1. Reset then single window a={12,33,156,26,199}, b={24,66,224,99,96} (element 0 first) -> score_out=289, score_valid exactly 2 cycles after win_valid; busy=1; no score_done.
2. NUM_WIN=16 back-to-back windows, window 5 all-equal (a=b), all others score 289 -> 16 score_valid pulses; score_done coincident with the 16th; best_score=0, best_idx=5.
3. Tie handling: windows 3 and 9 both score 10, others 289 -> best_idx=3, best_score=10.
4. Extreme values: a=all 255, b=all 0 -> score_out=1275. Also a=all 0, b=all 255 -> 1275 (abs diff symmetric, no overflow).
5. frame_clr asserted after 7 windows, in the same cycle as a win_valid -> no score_valid for that window or the 2 in flight; the next 16 windows form a full frame with indices 0..15; the previous best holds until the new score_done.
6. Async rst pulsed mid-frame, 3 windows in the pipe -> all outputs 0 immediately; no score_valid or score_done afterwards until new input; a following full frame reports correctly.
